// File: rtl/snn_pkg.sv
// Shared constants for the spiking-network event path: default field widths,
// event word layout and a packing helper used by the event logger.
package snn_pkg;

  localparam int TS_WIDTH_DEF   = 8;
  localparam int U_WIDTH_DEF    = 4;
  localparam int EVENT_WIDTH    = TS_WIDTH_DEF + U_WIDTH_DEF;

  // Field offsets inside an event word {timestamp, membrane potential}
  localparam int EV_U_LSB  = 0;
  localparam int EV_U_MSB  = U_WIDTH_DEF - 1;
  localparam int EV_TS_LSB = U_WIDTH_DEF;
  localparam int EV_TS_MSB = EVENT_WIDTH - 1;

  function automatic logic [EVENT_WIDTH-1:0] pack_event(
    input logic [TS_WIDTH_DEF-1:0] ts,
    input logic [U_WIDTH_DEF-1:0]  u
  );
    pack_event = {ts, u};
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data straight
// from storage; pointers carry a wrap bit so full/empty need no extra state.
module event_fifo
  import snn_pkg::*;
#(
  parameter int WIDTH = EVENT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [AW-1:0]    wr_idx_s;
  logic [AW-1:0]    rd_idx_s;

  assign wr_idx_s = wr_ptr_r[AW-1:0];
  assign rd_idx_s = rd_ptr_r[AW-1:0];

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_idx_s == rd_idx_s);
  assign level = wr_ptr_r - rd_ptr_r;

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle: the write lands in the slot being vacated.
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  assign rd_data = mem_r[rd_idx_s];

  // Pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage array, cleared on reset so the idle head reads as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_idx_s] <= wr_data;
    end
  end

endmodule

// File: rtl/spike_event_logger.sv
// Captures {timestamp, membrane potential} on every neuron spike into a small
// FIFO drained over valid/ready, and keeps sticky drop statistics.
module spike_event_logger
  import snn_pkg::*;
#(
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int U_WIDTH    = U_WIDTH_DEF,
  parameter int DEPTH      = 4,
  parameter int DROP_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          spike_in,
  input  logic [U_WIDTH-1:0]            u_in,
  input  logic                          clr_stat,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [TS_WIDTH+U_WIDTH-1:0]   ev_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  output logic [DROP_WIDTH-1:0]         drop_cnt
);

  localparam int EW = TS_WIDTH + U_WIDTH;

  logic [TS_WIDTH-1:0] ts_r;
  logic                push_req_s;
  logic                pop_s;
  logic                drop_s;
  logic                full_s;
  logic                empty_s;
  logic [EW-1:0]       event_s;
  logic                drop_sat_s;

  assign push_req_s = en && spike_in;
  assign pop_s      = ev_valid && ev_ready;
  assign event_s    = {ts_r, u_in};
  assign ev_valid   = !empty_s;
  // Only a push that finds the FIFO full with no departing head is lost
  assign drop_s     = push_req_s && full_s && !pop_s;
  assign drop_sat_s = (drop_cnt == {DROP_WIDTH{1'b1}});

  // Free-running timestamp, advancing only while enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_r <= {TS_WIDTH{1'b0}};
    end else if (en) begin
      ts_r <= ts_r + {{(TS_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Drop statistics; a clear in the same cycle as a drop leaves them at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= {DROP_WIDTH{1'b0}};
    end else if (clr_stat) begin
      overflow <= 1'b0;
      drop_cnt <= {DROP_WIDTH{1'b0}};
    end else if (drop_s) begin
      overflow <= 1'b1;
      if (!drop_sat_s) begin
        drop_cnt <= drop_cnt + {{(DROP_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  event_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_event_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req_s),
    .wr_data (event_s),
    .pop     (pop_s),
    .rd_data (ev_data),
    .full    (full_s),
    .empty   (empty_s),
    .level   (level)
  );

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed self-checking bench for spike_event_logger with hand-computed
// event words (TS_WIDTH=8, U_WIDTH=4, DEPTH=4, DROP_WIDTH=8).
module tb_spike_event_logger;

  logic        clk;
  logic        reset;
  logic        en;
  logic        spike_in;
  logic [3:0]  u_in;
  logic        clr_stat;
  logic        ev_valid;
  logic        ev_ready;
  logic [11:0] ev_data;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;

  spike_event_logger dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .spike_in (spike_in),
    .u_in     (u_in),
    .clr_stat (clr_stat),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0; spike_in = 1'b0; u_in = 4'h0; clr_stat = 1'b0; ev_ready = 1'b0;
    tick_n(2);
    reset = 1'b0;
  endtask

  logic [11:0] drain_exp [4];

  initial begin
    drain_exp[0] = 12'h011; drain_exp[1] = 12'h022;
    drain_exp[2] = 12'h033; drain_exp[3] = 12'h067;

    // Reset state
    do_reset();
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_data", 32'(ev_data), 32'h0);

    // Single spike at ts=5, u=9
    en = 1'b1;
    tick_n(5);
    spike_in = 1'b1; u_in = 4'h9;
    tick();
    spike_in = 1'b0;
    check("t1_valid", 32'(ev_valid), 32'h1);
    check("t1_data", 32'(ev_data), 32'h059);
    check("t1_level", 32'(level), 32'h1);
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t1_pop_valid", 32'(ev_valid), 32'h0);
    check("t1_pop_level", 32'(level), 32'h0);

    // en=0 freezes ts at 3 and masks spikes
    do_reset();
    en = 1'b1;
    tick_n(3);
    en = 1'b0; spike_in = 1'b1; u_in = 4'hA;
    tick_n(5);
    check("t2_frozen_valid", 32'(ev_valid), 32'h0);
    check("t2_frozen_level", 32'(level), 32'h0);
    en = 1'b1; u_in = 4'h2;
    tick();
    spike_in = 1'b0;
    check("t2_data", 32'(ev_data), 32'h032);
    check("t2_level", 32'(level), 32'h1);

    // Overflow: 6 spikes, ts 0..5, u=ts; last two dropped
    do_reset();
    en = 1'b1; spike_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      u_in = 4'(i);
      tick();
    end
    check("t3_level", 32'(level), 32'h4);
    check("t3_ovf", 32'(overflow), 32'h1);
    check("t3_drop", 32'(drop_cnt), 32'h2);
    check("t3_head", 32'(ev_data), 32'h000);

    // Full with simultaneous pop and push (ts=6, u=7): no drop
    ev_ready = 1'b1; u_in = 4'h7;
    tick();
    spike_in = 1'b0;
    check("t4_level", 32'(level), 32'h4);
    check("t4_drop", 32'(drop_cnt), 32'h2);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_valid", 32'(ev_valid), 32'h1);
      check("t4_drain_data", 32'(ev_data), 32'(drain_exp[i]));
      tick();
    end
    ev_ready = 1'b0;
    check("t4_empty_valid", 32'(ev_valid), 32'h0);
    check("t4_empty_level", 32'(level), 32'h0);

    // Timestamp wrap: spikes at ts=255 and ts=0
    do_reset();
    en = 1'b1;
    tick_n(255);
    spike_in = 1'b1; u_in = 4'h5;
    tick();
    u_in = 4'h6;
    tick();
    spike_in = 1'b0;
    check("t5_level", 32'(level), 32'h2);
    check("t5_head_ff", 32'(ev_data), 32'hFF5);
    ev_ready = 1'b1;
    tick();
    check("t5_head_00", 32'(ev_data), 32'h006);
    tick();
    ev_ready = 1'b0;
    check("t5_empty", 32'(ev_valid), 32'h0);

    // 300 drops saturate the counter; clear wins over a concurrent drop
    do_reset();
    en = 1'b1; spike_in = 1'b1;
    tick_n(304);
    check("t6_sat", 32'(drop_cnt), 32'hFF);
    check("t6_ovf", 32'(overflow), 32'h1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0; spike_in = 1'b0;
    check("t6_clr_ovf", 32'(overflow), 32'h0);
    check("t6_clr_drop", 32'(drop_cnt), 32'h0);
    check("t6_clr_level", 32'(level), 32'h4);

    // Reset mid-drain with three events buffered
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check("t7_level3", 32'(level), 32'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_rst_level", 32'(level), 32'h0);
    check("t7_rst_valid", 32'(ev_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
